// File: rtl/mc_main_fsm_pkg.sv
// Shared encodings for the multicycle ARM main controller: states, datapath mux selects
// and the per-state control word decode.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        MULEX  = 4'd10,
        FPUEX  = 4'd11,
        FPUWB  = 4'd12
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_FPUOUT    = 2'b11;

    localparam logic [1:0] SRCA_A  = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
    } ctrl_t;

    // Ungated control word for a state; unused encodings decode to all-zero.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            MEMADR: c.alu_src_b = SRCB_IMM;
            MEMRD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            MEMWR: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_w      = 1'b1;
            end
            EXECR: begin
                c.alu_src_b = SRCB_WD;
                c.alu_op    = 1'b1;
            end
            EXECI: begin
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = 1'b1;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURESULT;
                c.branch     = 1'b1;
            end
            MULEX: begin
                c.alu_src_b  = SRCB_WD;
                c.alu_op     = 1'b1;
                c.result_src = RES_ALURESULT;
                c.reg_w      = 1'b1;
            end
            FPUEX: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_WD;
            end
            FPUWB: begin
                c.result_src = RES_FPUOUT;
                c.reg_w      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Instruction fields, memory handshake and control outputs between the main FSM (master)
// and the datapath (slave).
interface mc_main_fsm_if #(parameter int CNT_W = 32);
    logic [1:0]       Op;
    logic [5:0]       Funct;
    logic             IsMul;
    logic             MemReady;
    logic             IRWrite;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             Branch;
    logic             AdrSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             ALUOp;
    logic [CNT_W-1:0] RetireCnt;

    modport master (
        input  Op, Funct, IsMul, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RetireCnt
    );

    modport slave (
        output Op, Funct, IsMul, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RetireCnt
    );
endinterface

// File: rtl/mc_main_fsm_retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_b,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_b) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM core: sequences fetch/decode/execute/writeback
// and drives datapath selects and write strobes.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC+4; waits on MemReady
//   DECODE | read registers, precompute PC+8
//   MEMADR | compute load/store address
//   MEMRD  | load data read; waits on MemReady
//   MEMWB  | write loaded data to register file
//   MEMWR  | store data write; waits on MemReady
//   EXECR  | ALU op, register operand
//   EXECI  | ALU op, immediate operand
//   ALUWB  | write ALU result
//   BRANCH | branch target to PC
//   MULEX  | single-cycle multiply with writeback
//   FPUEX  | FPU op, result captured at the edge
//   FPUWB  | write FPU result
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    mc_main_fsm_if.master   bus
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;
    logic   retire_en;

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    2'b00: begin
                        if (bus.IsMul)         nxt = MULEX;
                        else if (bus.Funct[5]) nxt = EXECI;
                        else                   nxt = EXECR;
                    end
                    2'b01:   nxt = MEMADR;
                    2'b10:   nxt = BRANCH;
                    default: nxt = FPUEX;
                endcase
            end
            MEMADR: nxt = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  nxt = bus.MemReady ? MEMWB : MEMRD;
            MEMWB:  nxt = FETCH;
            MEMWR:  nxt = bus.MemReady ? FETCH : MEMWR;
            EXECR:  nxt = ALUWB;
            EXECI:  nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            MULEX:  nxt = FETCH;
            FPUEX:  nxt = FPUWB;
            FPUWB:  nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            ctrl  <= decode_ctrl(FETCH);
        end else begin
            state <= nxt;
            ctrl  <= decode_ctrl(nxt);
        end
    end

    assign retire_en = reset && (state != FETCH) && (nxt == FETCH);

    retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk   (clk),
        .clr_b (reset),
        .en    (retire_en),
        .cnt   (bus.RetireCnt)
    );

    // Only FETCH and MEMWR raise IRWrite/NextPC/MemW, so MemReady gating applies uniformly.
    assign bus.IRWrite   = reset & ctrl.ir_write & bus.MemReady;
    assign bus.NextPC    = reset & ctrl.next_pc  & bus.MemReady;
    assign bus.MemW      = reset & ctrl.mem_w    & bus.MemReady;
    assign bus.RegW      = reset & ctrl.reg_w;
    assign bus.Branch    = reset & ctrl.branch;
    assign bus.AdrSrc    = ctrl.adr_src;
    assign bus.ALUSrcA   = ctrl.alu_src_a;
    assign bus.ALUSrcB   = ctrl.alu_src_b;
    assign bus.ResultSrc = ctrl.result_src;
    assign bus.ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: phase-queue model checked every cycle, plus directed
// instruction runs with hand-computed latencies and retire counts.
module tb_mc_main_fsm;

    localparam int CW = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mc_main_fsm_if #(.CNT_W(CW)) bus ();

    mc_main_fsm #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    string m_ph;
    string m_todo[$];
    int    m_cnt;
    bit    m_valid;

    function automatic void step();
        if (m_todo.size() == 0) begin
            m_ph  = "FETCH";
            m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
            m_ph = m_todo.pop_front();
        end
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_ph    = "FETCH";
            m_cnt   = 0;
            m_valid = 1'b1;
            m_todo.delete();
        end else if (m_valid) begin
            case (m_ph)
                "FETCH": if (bus.MemReady) m_ph = "DECODE";
                "DECODE": begin
                    m_todo.delete();
                    case (bus.Op)
                        2'd0: begin
                            if (bus.IsMul) m_todo.push_back("MULEX");
                            else begin
                                m_todo.push_back(bus.Funct[5] ? "EXECI" : "EXECR");
                                m_todo.push_back("ALUWB");
                            end
                        end
                        2'd1: m_todo.push_back("MEMADR");
                        2'd2: m_todo.push_back("BRANCH");
                        default: begin
                            m_todo.push_back("FPUEX");
                            m_todo.push_back("FPUWB");
                        end
                    endcase
                    step();
                end
                "MEMADR": begin
                    if (bus.Funct[0]) begin
                        m_todo.push_back("MEMRD");
                        m_todo.push_back("MEMWB");
                    end else begin
                        m_todo.push_back("MEMWR");
                    end
                    step();
                end
                "MEMRD", "MEMWR": if (bus.MemReady) step();
                default: step();
            endcase
        end
    end

    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RetireCnt}
    function automatic logic [16:0] exp_vec(string ph, logic rst, logic rdy, int cnt);
        logic ir, np, rw, mw, br, as, aop;
        logic [1:0] sa, sb, rs;
        logic [3:0] c;
        ir = 0; np = 0; rw = 0; mw = 0; br = 0; as = 0; aop = 0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        c = cnt[3:0];
        case (ph)
            "FETCH":  begin ir = rdy; np = rdy; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            "DECODE": begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            "MEMADR": sb = 2'b01;
            "MEMRD":  as = 1;
            "MEMWB":  begin rs = 2'b01; rw = 1; end
            "MEMWR":  begin as = 1; mw = rdy; end
            "EXECR":  aop = 1;
            "EXECI":  begin sb = 2'b01; aop = 1; end
            "ALUWB":  rw = 1;
            "BRANCH": begin sb = 2'b01; rs = 2'b10; br = 1; end
            "MULEX":  begin aop = 1; rs = 2'b10; rw = 1; end
            "FPUWB":  begin rs = 2'b11; rw = 1; end
            default:  ;
        endcase
        if (!rst) begin ir = 0; np = 0; rw = 0; mw = 0; br = 0; end
        return {ir, np, rw, mw, br, as, sa, sb, rs, aop, c};
    endfunction

    logic [16:0] act_vec;
    assign act_vec = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.AdrSrc,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.RetireCnt};

    always @(negedge clk) begin
        if (m_valid) begin
            logic [16:0] e;
            e = exp_vec(m_ph, reset, bus.MemReady, m_cnt);
            tests++;
            if (act_vec !== e) begin
                fails++;
                $display("FAIL cycle_%s @%0t: got %05h, expected %05h", m_ph, $time, act_vec, e);
            end
        end else if (!reset) begin
            tests++;
            if ({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch} !== 5'b0) begin
                fails++;
                $display("FAIL strobes_pre_reset: got nonzero, expected 0");
            end
        end
    end

    // ---------------- directed instruction runs ----------------
    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                             input logic ismul, input int lo_from, input int lo_n,
                             input int exp_cycles, input int exp_cnt, input int exp_adr,
                             input int exp_memw);
        int cyc, adr, mw;
        logic [CW-1:0] start;
        bit done;
        bus.Op = op; bus.Funct = funct; bus.IsMul = ismul;
        cyc = 0; adr = 0; mw = 0; done = 0;
        start = bus.RetireCnt;
        while (!done && cyc < 30) begin
            bus.MemReady = !(cyc >= lo_from && cyc < lo_from + lo_n);
            @(negedge clk);
            if (bus.AdrSrc) adr++;
            if (bus.MemW) mw++;
            @(posedge clk); #1;
            cyc++;
            if (bus.RetireCnt != start) done = 1;
        end
        bus.MemReady = 1'b1;
        check({name, "_cycles"}, cyc, exp_cycles);
        check({name, "_retire"}, int'(bus.RetireCnt), exp_cnt);
        check({name, "_adrsrc_cycles"}, adr, exp_adr);
        check({name, "_memw_cycles"}, mw, exp_memw);
    endtask

    initial begin
        tests = 0; fails = 0; m_valid = 0; m_cnt = 0; m_ph = "FETCH";
        reset = 1'b0;
        bus.MemReady = 1'b1; bus.Op = 2'b00; bus.Funct = 6'b000000; bus.IsMul = 1'b0;

        // 1. reset, strobes held low even with MemReady=1
        repeat (2) @(posedge clk);
        #1;
        check("reset_irwrite", int'(bus.IRWrite), 0);
        check("reset_nextpc", int'(bus.NextPC), 0);
        check("reset_alusrcb", int'(bus.ALUSrcB), 2);
        reset = 1'b1;
        #1;
        check("rel_irwrite", int'(bus.IRWrite), 1);
        check("rel_nextpc", int'(bus.NextPC), 1);
        check("rel_retire", int'(bus.RetireCnt), 0);

        // 2..5 instruction classes
        run_instr("add",   2'b00, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 0);
        run_instr("ldr",   2'b01, 6'b000001, 1'b0, 3, 3, 8, 2, 4, 0);
        run_instr("str",   2'b01, 6'b000000, 1'b0, 3, 1, 5, 3, 2, 1);
        run_instr("addi",  2'b00, 6'b100000, 1'b0, 0, 0, 4, 4, 0, 0);
        run_instr("mul",   2'b00, 6'b100000, 1'b1, 0, 0, 3, 5, 0, 0);
        run_instr("fpu",   2'b11, 6'b000000, 1'b0, 0, 0, 4, 6, 0, 0);
        run_instr("b",     2'b10, 6'b000000, 1'b0, 0, 0, 3, 7, 0, 0);
        run_instr("fstall",2'b00, 6'b000000, 1'b0, 0, 2, 6, 8, 0, 0);

        // 6. reset mid-MEMRD
        bus.Op = 2'b01; bus.Funct = 6'b000001; bus.MemReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.MemReady = 1'b0;
        @(posedge clk); #1;
        check("memrd_adrsrc", int'(bus.AdrSrc), 1);
        reset = 1'b0;
        bus.MemReady = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_irwrite", int'(bus.IRWrite), 0);
        check("rst_mid_adrsrc", int'(bus.AdrSrc), 0);
        check("rst_mid_resultsrc", int'(bus.ResultSrc), 2);
        check("rst_mid_retire", int'(bus.RetireCnt), 0);
        reset = 1'b1;
        #1;
        check("rst_mid_rel_irwrite", int'(bus.IRWrite), 1);

        // wrap of the 4-bit counter after 16 retirements
        for (int i = 0; i < 16; i++) begin
            run_instr("wrap_b", 2'b10, 6'b000000, 1'b0, 0, 0, 3, (i + 1) % 16, 0, 0);
        end
        check("wrap_final", int'(bus.RetireCnt), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
